// File: rtl/parity_frame_receiver_if.sv
// Downstream handshake for parity_frame_receiver: payload, valid and ready.
// The receiver drives data/valid through master; the consumer drives ready through slave.
interface parity_frame_receiver_if;
  logic [4:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/parity_frame_receiver.sv
// Strobed serial frame receiver: start, 5 data bits, even parity, stop.
// Good payloads go to a valid/ready holding register; parity, framing and overrun events pulse.
module parity_frame_receiver #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 rx,
  parity_frame_receiver_if.master dn,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [5:0] word, word_n;
  logic       stop_fire, free, good, load;
  logic       pe_n, fe_n, ov_n;

  // Word is filled by shifting in from the top: after six samples word[0]=d0 and word[5]=parity.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    case (state)
      IDLE: begin
        if (bit_en && !rx) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (bit_en) begin
          word_n = {rx, word[5:1]};
          if (cnt == 3'd5) begin
            state_n = STOP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    stop_fire = (state == STOP) && bit_en;
    free      = !dn.frame_valid || dn.frame_ready;
    fe_n      = stop_fire && !rx;
    pe_n      = stop_fire && rx && (^word);
    good      = stop_fire && rx && !(^word);
    load      = good && free;
    ov_n      = good && !free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      word           <= '0;
      dn.frame_data  <= '0;
      dn.frame_valid <= 1'b0;
      parity_err     <= 1'b0;
      framing_err    <= 1'b0;
      overrun        <= 1'b0;
      err_count      <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      word        <= word_n;
      parity_err  <= pe_n;
      framing_err <= fe_n;
      overrun     <= ov_n;
      if (load) begin
        dn.frame_data  <= word[4:0];
        dn.frame_valid <= 1'b1;
      end else if (dn.frame_ready) begin
        dn.frame_valid <= 1'b0;
      end
      if (pe_n && (err_count != '1))
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Bench for parity_frame_receiver: directed scenarios plus random frames,
// every cycle compared against a frame-level reference model (8-bit and 2-bit counter instances).
module tb_parity_frame_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic bit_en = 1'b0;
  logic rx = 1'b1;
  logic frame_ready = 1'b0;

  always #5 clk = ~clk;

  parity_frame_receiver_if ifa ();
  parity_frame_receiver_if ifb ();
  assign ifa.frame_ready = frame_ready;
  assign ifb.frame_ready = frame_ready;

  logic       pe_a, fe_a, ov_a, busy_a;
  logic [7:0] cnt_a;
  logic       pe_b, fe_b, ov_b, busy_b;
  logic [1:0] cnt_b;

  parity_frame_receiver #(.ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .dn(ifa.master),
    .parity_err(pe_a), .framing_err(fe_a), .overrun(ov_a),
    .err_count(cnt_a), .busy(busy_a)
  );

  parity_frame_receiver #(.ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx(rx), .dn(ifb.master),
    .parity_err(pe_b), .framing_err(fe_b), .overrun(ov_b),
    .err_count(cnt_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit rdy_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: collect strobed bits from a start bit into a queue, resolve at 8 bits.
  bit         q[$];
  logic       m_valid = 1'b0;
  logic [4:0] m_data  = '0;
  logic       m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  int         m_cnt8 = 0, m_cnt2 = 0;
  logic [4:0] md;
  logic       m_good;
  int         ones;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0; m_data = '0;
      m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_good = 1'b0;
      if (bit_en) begin
        if (q.size() > 0 || rx == 1'b0) q.push_back(rx);
        if (q.size() == 8) begin
          for (int i = 0; i < 5; i++) md[i] = q[i+1];
          ones = $countones({q[6], md});
          if (q[7] == 1'b0) m_fe = 1'b1;
          else if (ones % 2 == 1) begin
            m_pe = 1'b1;
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
          end else m_good = 1'b1;
          q.delete();
        end
      end
      if (m_good && (!m_valid || frame_ready)) begin
        m_valid = 1'b1;
        m_data  = md;
      end else begin
        if (m_good) m_ov = 1'b1;
        if (m_valid && frame_ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_a", 32'(ifa.frame_valid), 32'(m_valid));
      check("data_a",  32'(ifa.frame_data),  32'(m_data));
      check("perr_a",  32'(pe_a), 32'(m_pe));
      check("ferr_a",  32'(fe_a), 32'(m_fe));
      check("ovr_a",   32'(ov_a), 32'(m_ov));
      check("cnt_a",   32'(cnt_a), 32'(m_cnt8));
      check("busy_a",  32'(busy_a), 32'(q.size() != 0));
      check("valid_b", 32'(ifb.frame_valid), 32'(m_valid));
      check("data_b",  32'(ifb.frame_data),  32'(m_data));
      check("pulses_b", 32'({pe_b, fe_b, ov_b}), 32'({m_pe, m_fe, m_ov}));
      check("cnt_b",   32'(cnt_b), 32'(m_cnt2));
      check("busy_b",  32'(busy_b), 32'(q.size() != 0));
    end
  end

  task automatic tick(input logic be, input logic r);
    @(posedge clk);
    #1;
    bit_en = be;
    rx     = r;
    if (rdy_rand) frame_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [4:0] d, input logic par, input logic stp,
                            input int maxgap, input bit rdy_stop, input bit tail);
    logic [7:0] f;
    f = {stp, par, d, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) tick(1'b0, 1'($urandom_range(0, 1)));
      tick(1'b1, f[i]);
      if (i == 7 && rdy_stop) frame_ready = 1'b1;
    end
    if (tail) begin
      tick(1'b0, 1'b1);
      if (rdy_stop) frame_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] rd;
    logic       rp, rs;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(ifa.frame_valid), 32'd0);
    check("rst_cnt",   32'(cnt_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    #1 rst_n = 1'b1;

    // good frame 10110, held until a one-cycle ready
    send_frame(5'b10110, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("good_valid", 32'(ifa.frame_valid), 32'd1);
    check("good_data",  32'(ifa.frame_data), 32'h16);
    check("good_noerr", 32'({pe_a, fe_a, ov_a}), 32'd0);
    tick(1'b0, 1'b1);
    frame_ready = 1'b1;
    tick(1'b0, 1'b1);
    frame_ready = 1'b0;
    @(negedge clk);
    check("consume_valid", 32'(ifa.frame_valid), 32'd0);

    send_frame(5'b10110, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("par_pulse", 32'(pe_a), 32'd1);
    check("par_cnt",   32'(cnt_a), 32'd1);
    check("par_valid", 32'(ifa.frame_valid), 32'd0);

    send_frame(5'b00000, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("frm_pulse", 32'(fe_a), 32'd1);
    check("frm_cnt",   32'(cnt_a), 32'd1);
    check("frm_valid", 32'(ifa.frame_valid), 32'd0);

    send_frame(5'b10110, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    send_frame(5'b00011, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("ovr_pulse", 32'(ov_a), 32'd1);
    check("ovr_data",  32'(ifa.frame_data), 32'h16);
    send_frame(5'b00011, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    @(negedge clk);
    check("simul_ovr",   32'(ov_a), 32'd0);
    check("simul_valid", 32'(ifa.frame_valid), 32'd1);
    check("simul_data",  32'(ifa.frame_data), 32'h03);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_frame(5'b10110, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      @(negedge clk);
      check("sat_cnt2", 32'(cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
      check("sat_cnt8", 32'(cnt_a), 32'(i + 1));
    end

    // reset after three data bits
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    @(negedge clk);
    check("mid_busy", 32'(busy_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_outs", 32'({ifa.frame_valid, ifa.frame_data, pe_a, fe_a, ov_a}), 32'd0);
    check("mid_rst_cnt",  32'(cnt_a), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(5'b01101, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_valid", 32'(ifa.frame_valid), 32'd1);
    check("post_data",  32'(ifa.frame_data), 32'h0D);

    rdy_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rd = 5'($urandom);
      rp = ($urandom_range(0, 9) < 7) ? ^rd : ~(^rd);
      rs = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 4) == 0) tick(1'b1, 1'b1);
      send_frame(rd, rp, rs, $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)));
    end
    rdy_rand = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_receiver.md
# parity_frame_receiver

Serial front-end controller that sequences the 6-bit parity check for incoming link traffic. It assembles serial frames (start bit, 5 data bits, 1 even-parity bit, stop bit) under an external bit strobe. It evaluates the 6-bit word with the XOR-reduction parity rule and hands accepted 5-bit payloads downstream over a valid/ready holding register. Parity, framing and overrun events are flagged, and parity errors are counted for the status block.

## Interface
- ERR_CNT_W, 8, width of the saturating parity-error counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- bit_en  in  1  bit-period strobe; `rx` sampled only on cycles where `bit_en`=1
- rx  in  1  serial line, idle high, LSB first
- frame_data  out  5  payload d[4:0] of last accepted frame
- frame_valid  out  1  `frame_data` holds an unconsumed frame
- frame_ready  in  1  downstream accepts frame when high with `frame_valid`
- parity_err  out  1  one-cycle pulse: frame rejected for parity
- framing_err  out  1  one-cycle pulse: stop bit sampled as 0
- overrun  out  1  one-cycle pulse: good frame dropped, holding register full
- err_count  out  ERR_CNT_W  saturating count of parity errors
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, DATA, STOP.
  - IDLE: on `bit_en`=1 with `rx`=0 (start bit), go to DATA with bit counter = 0. `rx`=1 or `bit_en`=0 stays in IDLE.
  - DATA: on each `bit_en`, store `rx` into `word[cnt]` and increment `cnt`. After the 6th sample (`cnt`=5), go to STOP. `word[4:0]` = d0..d4 and `word[5]` = parity bit.
  - STOP: on `bit_en`, sample the stop bit and always return to IDLE. The frame is resolved at the same edge in the following priority order:
    1. `rx`=0: `framing_err`=1 for one cycle; frame discarded; parity not evaluated; `err_count` unchanged.
    2. Otherwise, if `^word[5:0]`=1 (odd number of ones): `parity_err`=1 for one cycle; `err_count` += 1, saturating at 2^ERR_CNT_W−1; frame discarded.
    3. Otherwise, the frame is good. If the holding register is free, load `frame_data`=`word[4:0]` and set `frame_valid`=1. If it is not free, `overrun`=1 for one cycle and the frame is dropped, with the holding register unchanged.
- Holding register is free at an edge when `frame_valid`=0, or when `frame_valid`=1 and `frame_ready`=1 at that edge.
- Handshake:
  - `frame_valid` stays high and `frame_data` stays stable until an edge with `frame_ready`=1. That edge clears `frame_valid`, unless a good frame loads at the same edge, in which case `frame_valid` stays 1 with the new data.
  - `frame_ready` is ignored while `frame_valid`=0.
- Only one error pulse can assert per frame; the three pulses are mutually exclusive.
- `rx` is don't-care on cycles where `bit_en`=0. Bits are never sampled without a strobe.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state = IDLE, `cnt`=0, `word`=0
  - `frame_data`=0, `frame_valid`=0
  - `parity_err`=0, `framing_err`=0, `overrun`=0
  - `err_count`=0, `busy`=0
- Reset mid-frame discards the partial frame. After release, the block waits in IDLE for a new start bit.
- Latency: if the stop bit is sampled in cycle N, result outputs (`frame_valid`/`frame_data` or the error pulse) are valid in cycle N+1.
- `busy` goes high the cycle after the start bit is sampled and goes low in cycle N+1.
- Back-to-back frames: a start bit with `bit_en` in cycle N+1 is accepted. There is no dead cycle beyond the stop bit.
- Pulses last exactly one cycle regardless of `bit_en` spacing.
- A frame needs exactly 8 `bit_en` strobes: start, 6 word bits, stop.

## Test plan
- Reset, then good frame: send start, 0,1,1,0,1, parity 1, stop 1 with `frame_ready`=0. Required: `frame_valid`=1 and `frame_data`=5'b10110 one cycle after the stop strobe; no error pulses. Raise `frame_ready` for one cycle; `frame_valid` drops the next cycle.
- Parity error: same payload with parity bit 0. Required: `parity_err` one-cycle pulse; `err_count` 0→1; `frame_valid` stays 0.
- Framing error: good payload 5'b00000, parity 0, stop 0. Required: `framing_err` pulse; `err_count` unchanged; no frame delivered.
- Overrun and simultaneous consume:
  - First case: hold `frame_ready`=0 with `frame_valid`=1 (data 5'b10110), then complete good frame 5'b00011 (parity 0). Required: `overrun` pulse; `frame_data` still 5'b10110.
  - Second case: repeat with `frame_ready`=1 on the resolving edge. Required: no `overrun`; `frame_valid` stays 1 with `frame_data`=5'b00011.
- Saturation with ERR_CNT_W=2: send 5 parity-error frames. Required: `err_count` sequence 1,2,3,3,3.
- Reset mid-frame: assert `rst_n`=0 after 3 data bits. Required: `busy`=0 and all outputs zero immediately; a subsequent full good frame is received correctly.
